// File: rtl/gb_bus_pkg.sv
// Shared types and constants for the Game Boy cartridge bus master.
package gb_bus_pkg;

   typedef enum logic [2:0] {
      RST_HOLD = 3'd0,
      IDLE     = 3'd1,
      SETUP    = 3'd2,
      STROBE   = 3'd3,
      HOLD     = 3'd4
   } gb_state_e;

   localparam logic [15:0] GB_CS_LO   = 16'hA000;
   localparam logic [15:0] GB_CS_HI   = 16'hFDFF;
   localparam logic [7:0]  RAM_EN_KEY = 8'h0A;

   // Mapper register regions, selected by address bits [15:12]
   localparam logic [3:0] REG_RAMEN_0 = 4'h0;
   localparam logic [3:0] REG_RAMEN_1 = 4'h1;
   localparam logic [3:0] REG_ROMB_LO = 4'h2;
   localparam logic [3:0] REG_ROMB_HI = 4'h3;
   localparam logic [3:0] REG_RAMB_0  = 4'h4;
   localparam logic [3:0] REG_RAMB_1  = 4'h5;

   function automatic logic in_cs_range(input logic [15:0] addr);
      return (addr >= GB_CS_LO) && (addr <= GB_CS_HI);
   endfunction

endpackage

// File: rtl/gb_mbc_shadow.sv
// Shadow copy of the cartridge mapper bank registers, updated on completed writes.
module gb_mbc_shadow
   import gb_bus_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       wr_stb,
   input  logic [3:0] wr_region,
   input  logic [7:0] wr_data,
   output logic [8:0] rom_bank,
   output logic [3:0] ram_bank,
   output logic       ram_en
);

   logic [8:0] rom_bank_r;
   logic [3:0] ram_bank_r;
   logic       ram_en_r;

   // Decode each completed write into the matching bank register
   always_ff @(posedge clk) begin
      if (rst) begin
         rom_bank_r <= 9'h001;
         ram_bank_r <= 4'h0;
         ram_en_r   <= 1'b0;
      end else if (wr_stb) begin
         case (wr_region)
            REG_RAMEN_0, REG_RAMEN_1: ram_en_r        <= (wr_data == RAM_EN_KEY);
            REG_ROMB_LO:              rom_bank_r[7:0] <= wr_data;
            REG_ROMB_HI:              rom_bank_r[8]   <= wr_data[0];
            REG_RAMB_0, REG_RAMB_1:   ram_bank_r      <= wr_data[3:0];
            default:                  ram_en_r        <= ram_en_r;
         endcase
      end else begin
         ram_en_r <= ram_en_r;
      end
   end

   assign rom_bank = rom_bank_r;
   assign ram_bank = ram_bank_r;
   assign ram_en   = ram_en_r;

endmodule

// File: rtl/gb_bus_master.sv
// Game Boy cartridge bus initiator: single-byte host requests to timed /CS,/RD,/WR cycles.
// Optional mapper shadow registers are enabled with GB_BUS_MASTER_SHADOW_EN.
module gb_bus_master
   import gb_bus_pkg::*;
#(
   parameter int T_SETUP  = 2,
   parameter int T_STROBE = 4,
   parameter int T_HOLD   = 1,
   parameter int T_RST    = 16
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        REQ_VALID,
   output logic        REQ_READY,
   input  logic [15:0] REQ_ADDR,
   input  logic        REQ_WE,
   input  logic [7:0]  REQ_WDATA,
   output logic        RSP_VALID,
   output logic [7:0]  RSP_RDATA,
   output logic [15:0] GB_A,
   output logic [7:0]  GB_DO,
   output logic        GB_DOE,
   input  logic [7:0]  GB_DI,
   output logic        GB_CS,
   output logic        GB_RD,
   output logic        GB_WR,
   output logic        GB_RST_N
`ifdef GB_BUS_MASTER_SHADOW_EN
   ,
   output logic [8:0]  SHADOW_ROM_BANK,
   output logic [3:0]  SHADOW_RAM_BANK,
   output logic [0:0]  SHADOW_RAM_EN
`endif
);

   localparam logic [7:0] T_SETUP_C  = 8'(T_SETUP);
   localparam logic [7:0] T_STROBE_C = 8'(T_STROBE);
   localparam logic [7:0] T_HOLD_C   = 8'(T_HOLD);
   localparam logic [7:0] T_RST_C    = 8'(T_RST);

   gb_state_e   state_r;
   logic [7:0]  cnt_r;
   logic        we_r;
   logic        ready_r;
   logic        rsp_valid_r;
   logic [7:0]  rdata_r;
   logic [15:0] a_r;
   logic [7:0]  do_r;
   logic        doe_r;
   logic        cs_r;
   logic        rd_r;
   logic        wr_r;
   logic        rst_n_r;

   // Bus-cycle sequencer; every pad and handshake output is a register here
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_r     <= RST_HOLD;
         cnt_r       <= T_RST_C;
         we_r        <= 1'b0;
         ready_r     <= 1'b0;
         rsp_valid_r <= 1'b0;
         rdata_r     <= 8'h00;
         a_r         <= 16'h0000;
         do_r        <= 8'h00;
         doe_r       <= 1'b0;
         cs_r        <= 1'b1;
         rd_r        <= 1'b1;
         wr_r        <= 1'b1;
         rst_n_r     <= 1'b0;
      end else begin
         rsp_valid_r <= 1'b0;
         case (state_r)
            RST_HOLD: begin
               if (cnt_r == 8'd1) begin
                  state_r <= IDLE;
                  rst_n_r <= 1'b1;
                  ready_r <= 1'b1;
               end else begin
                  cnt_r <= cnt_r - 8'd1;
               end
            end
            IDLE: begin
               if (REQ_VALID && ready_r) begin
                  state_r <= SETUP;
                  cnt_r   <= T_SETUP_C;
                  ready_r <= 1'b0;
                  we_r    <= REQ_WE;
                  a_r     <= REQ_ADDR;
                  cs_r    <= ~in_cs_range(REQ_ADDR);
                  doe_r   <= REQ_WE;
                  if (REQ_WE) begin
                     do_r <= REQ_WDATA;
                  end else begin
                     do_r <= do_r;
                  end
               end else begin
                  ready_r <= 1'b1;
               end
            end
            SETUP: begin
               if (cnt_r == 8'd1) begin
                  state_r <= STROBE;
                  cnt_r   <= T_STROBE_C;
                  rd_r    <= we_r;
                  wr_r    <= ~we_r;
               end else begin
                  cnt_r <= cnt_r - 8'd1;
               end
            end
            STROBE: begin
               if (cnt_r == 8'd1) begin
                  state_r <= HOLD;
                  cnt_r   <= T_HOLD_C;
                  rd_r    <= 1'b1;
                  wr_r    <= 1'b1;
                  if (!we_r) begin
                     rdata_r <= GB_DI;
                  end else begin
                     rdata_r <= rdata_r;
                  end
               end else begin
                  cnt_r <= cnt_r - 8'd1;
               end
            end
            HOLD: begin
               if (cnt_r == 8'd1) begin
                  state_r     <= IDLE;
                  ready_r     <= 1'b1;
                  rsp_valid_r <= 1'b1;
                  cs_r        <= 1'b1;
                  doe_r       <= 1'b0;
               end else begin
                  cnt_r <= cnt_r - 8'd1;
               end
            end
            default: begin
               state_r <= RST_HOLD;
               cnt_r   <= T_RST_C;
               ready_r <= 1'b0;
               doe_r   <= 1'b0;
               cs_r    <= 1'b1;
               rd_r    <= 1'b1;
               wr_r    <= 1'b1;
               rst_n_r <= 1'b0;
            end
         endcase
      end
   end

   assign REQ_READY = ready_r;
   assign RSP_VALID = rsp_valid_r;
   assign RSP_RDATA = rdata_r;
   assign GB_A      = a_r;
   assign GB_DO     = do_r;
   assign GB_DOE    = doe_r;
   assign GB_CS     = cs_r;
   assign GB_RD     = rd_r;
   assign GB_WR     = wr_r;
   assign GB_RST_N  = rst_n_r;

`ifdef GB_BUS_MASTER_SHADOW_EN
   // Fires on the same edge that raises RSP_VALID for a write
   logic wr_done_s;
   assign wr_done_s = (state_r == HOLD) && (cnt_r == 8'd1) && we_r;

   gb_mbc_shadow u_shadow (
      .clk       (CLK),
      .rst       (RST),
      .wr_stb    (wr_done_s),
      .wr_region (a_r[15:12]),
      .wr_data   (do_r),
      .rom_bank  (SHADOW_ROM_BANK),
      .ram_bank  (SHADOW_RAM_BANK),
      .ram_en    (SHADOW_RAM_EN[0])
   );
`endif

endmodule

// File: tb/tb_gb_bus_master.sv
// Self-checking bench for gb_bus_master: transaction-level model compared every cycle plus directed scenarios.
module tb_gb_bus_master;

   localparam int T_SETUP  = 2;
   localparam int T_STROBE = 4;
   localparam int T_HOLD   = 1;
   localparam int T_RST    = 16;
   localparam int LAT      = T_SETUP + T_STROBE + T_HOLD;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        valid = 1'b0;
   logic        ready_o;
   logic [15:0] addr = 16'h0000;
   logic        we = 1'b0;
   logic [7:0]  wdata = 8'h00;
   logic        rsp_valid;
   logic [7:0]  rsp_rdata;
   logic [15:0] gb_a;
   logic [7:0]  gb_do;
   logic        gb_doe;
   logic [7:0]  di = 8'h00;
   logic        gb_cs;
   logic        gb_rd;
   logic        gb_wr;
   logic        gb_rst_n;
`ifdef GB_BUS_MASTER_SHADOW_EN
   logic [8:0]  sh_rom;
   logic [3:0]  sh_ramb;
   logic [0:0]  sh_ramen;
`endif

   int errors = 0;
   int checks = 0;

   gb_bus_master #(.T_SETUP(T_SETUP), .T_STROBE(T_STROBE), .T_HOLD(T_HOLD), .T_RST(T_RST)) dut (
      .CLK(clk), .RST(rst), .REQ_VALID(valid), .REQ_READY(ready_o), .REQ_ADDR(addr),
      .REQ_WE(we), .REQ_WDATA(wdata), .RSP_VALID(rsp_valid), .RSP_RDATA(rsp_rdata),
      .GB_A(gb_a), .GB_DO(gb_do), .GB_DOE(gb_doe), .GB_DI(di), .GB_CS(gb_cs),
      .GB_RD(gb_rd), .GB_WR(gb_wr), .GB_RST_N(gb_rst_n)
`ifdef GB_BUS_MASTER_SHADOW_EN
      , .SHADOW_ROM_BANK(sh_rom), .SHADOW_RAM_BANK(sh_ramb), .SHADOW_RAM_EN(sh_ramen)
`endif
   );

   always #5 clk = ~clk;

   // Transaction-level model: edges since reset release, edges since accept
   int          m_rst_cnt = 0;
   bit          m_busy = 1'b0;
   int          m_k = 0;
   bit          m_we = 1'b0;
   bit          m_rsp = 1'b0;
   logic [15:0] m_a = 16'h0000;
   logic [7:0]  m_do = 8'h00;
   logic [7:0]  m_rdata = 8'h00;
   logic [8:0]  m_rom = 9'h001;
   logic [3:0]  m_ramb = 4'h0;
   logic        m_ramen = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_update();
      m_rsp = 1'b0;
      if (rst) begin
         m_rst_cnt = 0; m_busy = 1'b0; m_k = 0; m_we = 1'b0;
         m_a = 16'h0000; m_do = 8'h00; m_rdata = 8'h00;
         m_rom = 9'h001; m_ramb = 4'h0; m_ramen = 1'b0;
      end else if (m_rst_cnt < T_RST) begin
         m_rst_cnt++;
      end else if (m_busy) begin
         m_k++;
         if (m_k == T_SETUP + T_STROBE && !m_we) m_rdata = di;
         if (m_k == LAT) begin
            m_busy = 1'b0;
            m_rsp  = 1'b1;
            if (m_we) begin
               case (m_a[15:12])
                  4'h0, 4'h1: m_ramen = (m_do == 8'h0A);
                  4'h2:       m_rom[7:0] = m_do;
                  4'h3:       m_rom[8] = m_do[0];
                  4'h4, 4'h5: m_ramb = m_do[3:0];
                  default:    m_ramb = m_ramb;
               endcase
            end
         end
      end else if (valid) begin
         m_busy = 1'b1; m_k = 0; m_we = we; m_a = addr;
         if (we) m_do = wdata;
      end
   endtask

   task automatic compare_all();
      bit rst_n_e, strobe_e, cs_sel;
      rst_n_e  = (m_rst_cnt >= T_RST);
      strobe_e = m_busy && (m_k >= T_SETUP) && (m_k < T_SETUP + T_STROBE);
      cs_sel   = (m_a >= 16'hA000) && (m_a <= 16'hFDFF);
      chk("rst_n", gb_rst_n, rst_n_e);
      chk("ready", ready_o, rst_n_e && !m_busy);
      chk("rsp_valid", rsp_valid, m_rsp);
      chk("rsp_rdata", rsp_rdata, m_rdata);
      chk("gb_a", gb_a, m_a);
      chk("gb_do", gb_do, m_do);
      chk("gb_doe", gb_doe, m_busy && m_we);
      chk("gb_cs", gb_cs, !(m_busy && cs_sel));
      chk("gb_rd", gb_rd, !(strobe_e && !m_we));
      chk("gb_wr", gb_wr, !(strobe_e && m_we));
      chk("rd_wr_excl", !gb_rd && !gb_wr, 1'b0);
      chk("doe_rd_excl", gb_doe && !gb_rd, 1'b0);
`ifdef GB_BUS_MASTER_SHADOW_EN
      chk("sh_rom", sh_rom, m_rom);
      chk("sh_ramb", sh_ramb, m_ramb);
      chk("sh_ramen", sh_ramen, m_ramen);
`endif
   endtask

   task automatic tick();
      @(posedge clk);
      model_update();
      @(negedge clk);
      compare_all();
   endtask

   task automatic release_check();
      int n;
      bit bad;
      rst = 1'b0; n = 0; bad = 1'b0;
      while (!gb_rst_n && n < 40) begin
         tick();
         n++;
         if (rsp_valid || !gb_rd || !gb_wr || !gb_cs || gb_doe) bad = 1'b1;
         if (!gb_rst_n && ready_o) bad = 1'b1;
      end
      chk("rst_release_len", n, 32'd16);
      chk("ready_at_release", ready_o, 1'b1);
      chk("no_bus_in_rst", bad, 1'b0);
   endtask

   task automatic run_txn(input logic [15:0] ad, input logic w, input logic [7:0] wd, input logic [7:0] d,
                          output int lat, output int rdl, output int wrl, output int csl,
                          output int doec, output int wr_first);
      int guard;
      guard = 0;
      while (!ready_o && guard < 50) begin tick(); guard++; end
      valid = 1'b1; addr = ad; we = w; wdata = wd; di = d;
      tick();
      valid = 1'b0;
      lat = 0; rdl = 0; wrl = 0; csl = 0; doec = 0; wr_first = -1;
      forever begin
         if (!gb_rd) rdl++;
         if (!gb_wr) begin if (wr_first < 0) wr_first = lat; wrl++; end
         if (!gb_cs) csl++;
         if (gb_doe) doec++;
         if (rsp_valid || lat >= 30) break;
         tick();
         lat++;
      end
   endtask

   initial begin
      int lat, rdl, wrl, csl, doec, wrf, n, gap, ph;
      logic [15:0] picks [6];
      picks[0] = 16'h9FFF; picks[1] = 16'hA000; picks[2] = 16'hFDFF;
      picks[3] = 16'hFE00; picks[4] = 16'h0150; picks[5] = 16'h4000;

      // Reset release
      rst = 1'b1;
      repeat (3) tick();
      chk("reset_rst_n", gb_rst_n, 1'b0);
      chk("reset_cs", gb_cs, 1'b1);
      release_check();

      // Read 0x0150
      run_txn(16'h0150, 1'b0, 8'h00, 8'hCE, lat, rdl, wrl, csl, doec, wrf);
      chk("rd_latency", lat, 32'd7);
      chk("rd_low_len", rdl, 32'd4);
      chk("rd_cs_low", csl, 32'd0);
      chk("rd_doe", doec, 32'd0);
      chk("rd_data", rsp_rdata, 8'hCE);

      // Write 0xA000
      run_txn(16'hA000, 1'b1, 8'h5A, 8'h00, lat, rdl, wrl, csl, doec, wrf);
      chk("wr_latency", lat, 32'd7);
      chk("wr_cs_low", csl, 32'd7);
      chk("wr_low_len", wrl, 32'd4);
      chk("wr_start", wrf, 32'd2);
      chk("wr_doe_len", doec, 32'd7);
      chk("wr_do", gb_do, 8'h5A);
      chk("wr_rdata_kept", rsp_rdata, 8'hCE);
      tick();
      chk("rsp_one_pulse", rsp_valid, 1'b0);

      // Back-to-back reads 0x4000 then 0x4001
      valid = 1'b1; addr = 16'h4000; we = 1'b0; di = 8'h3C;
      tick();
      addr = 16'h4001;
      gap = 0; ph = 0; n = 0;
      while (n < 40) begin
         if (ph == 0 && !gb_rd) ph = 1;
         else if (ph == 1 && gb_rd) begin ph = 2; gap++; end
         else if (ph == 2 && gb_rd) gap++;
         else if (ph == 2 && !gb_rd) ph = 3;
         if (rsp_valid && valid) begin
            chk("b2b_first_rdata", rsp_rdata, 8'h3C);
            chk("b2b_ready_in_rsp", ready_o, 1'b1);
            di = 8'hA7;
            tick();
            chk("b2b_accepted", ready_o, 1'b0);
            chk("b2b_addr", gb_a, 16'h4001);
            valid = 1'b0;
         end else if (rsp_valid) begin
            break;
         end else begin
            tick();
         end
         n++;
      end
      chk("b2b_phase", ph, 32'd3);
      chk("b2b_rd_gap", gap, 32'd4);
      chk("b2b_second_rdata", rsp_rdata, 8'hA7);

      // Reset during a write strobe
      valid = 1'b1; addr = 16'hA123; we = 1'b1; wdata = 8'h33;
      tick();
      valid = 1'b0; n = 0;
      while (gb_wr && n < 20) begin tick(); n++; end
      chk("abort_reached_strobe", gb_wr, 1'b0);
      rst = 1'b1;
      tick();
      chk("abort_wr", gb_wr, 1'b1);
      chk("abort_doe", gb_doe, 1'b0);
      chk("abort_rst_n", gb_rst_n, 1'b0);
      chk("abort_rsp", rsp_valid, 1'b0);
      release_check();

`ifdef GB_BUS_MASTER_SHADOW_EN
      run_txn(16'h2000, 1'b1, 8'h12, 8'h00, lat, rdl, wrl, csl, doec, wrf);
      run_txn(16'h3000, 1'b1, 8'h01, 8'h00, lat, rdl, wrl, csl, doec, wrf);
      run_txn(16'h0000, 1'b1, 8'h0A, 8'h00, lat, rdl, wrl, csl, doec, wrf);
      run_txn(16'h4000, 1'b1, 8'h07, 8'h00, lat, rdl, wrl, csl, doec, wrf);
      chk("shadow_rom_bank", sh_rom, 9'h112);
      chk("shadow_ram_en_on", sh_ramen, 1'b1);
      chk("shadow_ram_bank", sh_ramb, 4'h7);
      run_txn(16'h1000, 1'b1, 8'h00, 8'h00, lat, rdl, wrl, csl, doec, wrf);
      chk("shadow_ram_en_off", sh_ramen, 1'b0);
`endif

      // Randomized traffic, including occasional resets
      for (int i = 0; i < 1500; i++) begin
         rst   = ($urandom_range(0, 299) == 0);
         valid = $urandom_range(0, 1);
         case ($urandom_range(0, 3))
            0:       addr = 16'($urandom);
            1:       addr = picks[$urandom_range(0, 5)];
            2:       addr = {4'($urandom_range(0, 6)), 12'($urandom)};
            default: addr = 16'hA000 + 16'($urandom_range(0, 15));
         endcase
         we    = $urandom_range(0, 1);
         wdata = ($urandom_range(0, 3) == 0) ? 8'h0A : 8'($urandom);
         di    = 8'($urandom);
         tick();
      end
      rst = 1'b0; valid = 1'b0;
      repeat (LAT + 2) tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
